axi_fb_rd_dma: RTL

AXI_FB_RD_DMA -- requirements
Module: axi_fb_rd_dma

---
 rtl/axi_fb_pkg.sv | 12 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/axi_fb_rd_dma.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/axi_fb_pkg.sv
// Shared definitions for the frame-buffer read DMA: AXI encodings and the
// sequencer state type.
package axi_fb_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data always shows the head
// entry, count reports occupancy. DP must be a power of two.
module sync_fifo #(
    parameter int DW = 33,
    parameter int DP = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DW-1:0]         wr_data,
    input  logic                  rd_en,
    output logic [DW-1:0]         rd_data,
    output logic                  empty,
    output logic [$clog2(DP):0]   count
);
    localparam int AW = $clog2(DP);

    logic [DW-1:0] mem [DP];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          push;
    logic          pop;

    // Extra pointer MSB distinguishes full from empty.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DP));
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/axi_fb_rd_dma.sv
// Frame-buffer read DMA: issues credit-limited AXI INCR bursts over a frame
// and streams the returned words out with a start-of-frame tag.
// Optional RRESP error checking is enabled by defining AXI_FB_RD_RRESP_CHK_EN.
module axi_fb_rd_dma
    import axi_fb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 1024,
    parameter int MAX_OUTST  = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              enable,
    input  logic [31:0]       cfg_base,
    input  logic [31:0]       cfg_frame_bytes,
    output logic [31:0]       ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              busy,
    output logic              err
);
    localparam int          BYTES_PER_BEAT = DATA_W / 8;
    localparam int          BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam logic [31:0] BURST_BYTES    = 32'(BURST_LEN * BYTES_PER_BEAT);
    localparam int          CNT_W          = $clog2(FIFO_DEPTH) + 1;
    localparam int          OB_W           = $clog2(MAX_OUTST + 1);

    state_t            state;
    state_t            state_nxt;
    logic              start_ar;
    logic              ar_hs;
    logic              r_beat;
    logic              credit_ok;
    logic              clear_pos;
    logic              err_q;
    logic              rready_q;
    logic [31:0]       offset;
    logic [31:0]       offset_inc;
    logic [31:0]       cur_base;
    logic [31:0]       cur_frame;
    logic [31:0]       beat_cnt;
    logic [31:0]       beats_per_frame;
    logic [CNT_W-1:0]  outst_beats;
    logic [CNT_W-1:0]  fifo_count;
    logic [OB_W-1:0]   outst_bursts;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_rd;

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = 3'(BEAT_SHIFT);
    assign ARBURST = AXI_BURST_INCR;
    assign RREADY  = rready_q;

    assign ar_hs           = ARVALID && ARREADY;
    assign r_beat          = RVALID && rready_q;
    assign offset_inc      = offset + BURST_BYTES;
    assign beats_per_frame = cur_frame >> BEAT_SHIFT;
    assign busy            = ARVALID || (outst_bursts != '0);
    assign err             = err_q;

    // Beats already buffered plus beats still owed must leave room for a whole burst.
    assign credit_ok = (32'(fifo_count) + 32'(outst_beats) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH))
                    && (32'(outst_bursts) < 32'(MAX_OUTST))
                    && !err_q;

    assign clear_pos = (outst_bursts == '0)
                    && ((state == S_DRAIN) || (state == S_IDLE && !enable));

    always_comb begin
        state_nxt = state;
        start_ar  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!enable && outst_bursts != '0) begin
                    state_nxt = S_DRAIN;
                end else if (enable && credit_ok) begin
                    state_nxt = S_AR;
                    start_ar  = 1'b1;
                end
            end
            S_AR: begin
                // A pending request always completes, even if enable dropped.
                if (ARREADY) state_nxt = enable ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (outst_bursts == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state        <= S_IDLE;
            ARVALID      <= 1'b0;
            ARADDR       <= '0;
            rready_q     <= 1'b0;
            offset       <= '0;
            cur_base     <= '0;
            cur_frame    <= '0;
            beat_cnt     <= '0;
            outst_beats  <= '0;
            outst_bursts <= '0;
        end else begin
            state    <= state_nxt;
            rready_q <= 1'b1;

            if (start_ar) begin
                ARVALID <= 1'b1;
                if (offset == '0) begin
                    cur_base  <= cfg_base;
                    cur_frame <= cfg_frame_bytes;
                    ARADDR    <= cfg_base;
                end else begin
                    ARADDR <= cur_base + offset;
                end
            end else if (ar_hs) begin
                ARVALID <= 1'b0;
            end

            if (ar_hs) offset <= (offset_inc >= cur_frame) ? '0 : offset_inc;
            else if (clear_pos) offset <= '0;

            if (clear_pos) beat_cnt <= '0;
            else if (r_beat) beat_cnt <= (beat_cnt == beats_per_frame - 32'd1) ? '0 : beat_cnt + 32'd1;

            unique case ({ar_hs, r_beat})
                2'b10:   outst_beats <= outst_beats + CNT_W'(BURST_LEN);
                2'b01:   outst_beats <= outst_beats - CNT_W'(1);
                2'b11:   outst_beats <= outst_beats + CNT_W'(BURST_LEN - 1);
                default: outst_beats <= outst_beats;
            endcase

            unique case ({ar_hs, r_beat && RLAST})
                2'b10:   outst_bursts <= outst_bursts + OB_W'(1);
                2'b01:   outst_bursts <= outst_bursts - OB_W'(1);
                default: outst_bursts <= outst_bursts;
            endcase
        end
    end

`ifdef AXI_FB_RD_RRESP_CHK_EN
    // Sticky until reset; in-flight beats keep flowing, only new requests stop.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) err_q <= 1'b0;
        else if (r_beat && RRESP != AXI_RESP_OKAY) err_q <= 1'b1;
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^RRESP;
    assign err_q        = 1'b0;
`endif

    sync_fifo #(
        .DW (DATA_W + 1),
        .DP (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (r_beat),
        .wr_data ({(beat_cnt == '0), RDATA}),
        .rd_en   (m_ready),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_rd[DATA_W-1:0];
    assign m_sof   = fifo_rd[DATA_W] && !fifo_empty;
endmodule
